// File: rtl/capture_cps_limiter_pkg.sv
// capture_cps_pkg: shared types and helpers for the capture-path rate limiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: limiter FSM state enum, counter width, saturating increment.
package capture_cps_pkg;

    localparam int CNT_W = 32;

    typedef enum logic {
        PASS  = 1'b0,
        LIMIT = 1'b1
    } cps_state_e;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/capture_cps_limiter_if.sv
// capture_cps_limiter_if: event input stream plus limited output stream.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams; slave is the limiter's view.
// Signals: evt_valid/evt_data/evt_ready (in stream), out_valid/out_data/out_ready (out stream).
interface capture_cps_limiter_if #(
    parameter int DATA_W = 64
);
    logic              evt_valid;
    logic [DATA_W-1:0] evt_data;
    logic              evt_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output evt_valid, evt_data, out_ready,
        input  evt_ready, out_valid, out_data
    );

    modport slave (
        input  evt_valid, evt_data, out_ready,
        output evt_ready, out_valid, out_data
    );
endinterface

// File: rtl/capture_cps_limiter_timer.sv
// cps_window_timer: free-running rate-window counter, 0..WINDOW_CYC-1 then wrap.
// Latency: win_tick is decoded from the count register, high on the window's last cycle.
// Backpressure: none; runs every cycle.
// Ports: user_clk, user_rst_n (async active-low), win_tick (out).
module cps_window_timer #(
    parameter int WINDOW_CYC = 250000000
) (
    input  logic user_clk,
    input  logic user_rst_n,
    output logic win_tick
);
    localparam int            TW   = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(WINDOW_CYC - 1);

    logic [TW-1:0] cnt;

    assign win_tick = (cnt == LAST);

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            cnt <= '0;
        end else if (win_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/capture_cps_limiter.sv
// capture_cps_limiter: passes at most lim_q photon events per window, drops the rest.
// Latency: 1 cycle from accepted event to out_valid; dropped events never reach the output.
// Backpressure: evt_ready = !out_valid || out_ready in both states, so drops also wait on the output register.
// Ports: user_clk, user_rst_n, cps_lim, bus (slave: evt_* in, out_* out), win_tick, limiting,
//        last_pass_cnt/last_drop_cnt (previous-window stats, only built with CPS_LIM_STATS_EN).
module capture_cps_limiter #(
    parameter int DATA_W     = 64,
    parameter int WINDOW_CYC = 250000000,
    parameter int CNT_W      = 32
) (
    input  logic                 user_clk,
    input  logic                 user_rst_n,
    input  logic [31:0]          cps_lim,
    capture_cps_limiter_if.slave bus,
    output logic                 win_tick,
    output logic                 limiting,
    output logic [CNT_W-1:0]     last_pass_cnt,
    output logic [CNT_W-1:0]     last_drop_cnt
);
    import capture_cps_pkg::*;

    cps_state_e        state, state_nxt;
    logic [CNT_W-1:0]  lim_q;
    logic [CNT_W-1:0]  pass_cnt, pass_nxt;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              evt_rdy;
    logic              evt_acc;
    logic              evt_pass;

    cps_window_timer #(.WINDOW_CYC(WINDOW_CYC)) u_timer (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .win_tick   (win_tick)
    );

    assign evt_rdy       = !out_valid_q || bus.out_ready;
    assign evt_acc       = bus.evt_valid && evt_rdy;
    assign evt_pass      = evt_acc && (state == PASS);
    // pass_nxt includes an event accepted on the tick cycle, so the snapshot sees it.
    assign pass_nxt      = evt_pass ? sat_inc(pass_cnt) : pass_cnt;

    assign bus.evt_ready = evt_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state <= PASS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (win_tick) begin
            state_nxt = PASS;
        end else if (evt_pass && (lim_q != '0) && (pass_nxt == lim_q)) begin
            state_nxt = LIMIT;
        end
    end

    always_comb begin
        limiting = (state == LIMIT);
    end

    // A new limit only applies from the window boundary onward.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            lim_q    <= '0;
            pass_cnt <= '0;
        end else if (win_tick) begin
            lim_q    <= CNT_W'(cps_lim);
            pass_cnt <= '0;
        end else begin
            pass_cnt <= pass_nxt;
        end
    end

    // Accepting implies the register is empty or draining, so a drop simply empties it.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (evt_acc) begin
            out_valid_q <= evt_pass;
            if (evt_pass) begin
                out_data_q <= bus.evt_data;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef CPS_LIM_STATS_EN
    logic [CNT_W-1:0] drop_cnt, drop_nxt;
    logic [CNT_W-1:0] last_pass_q, last_drop_q;

    assign drop_nxt = (evt_acc && (state == LIMIT)) ? sat_inc(drop_cnt) : drop_cnt;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            drop_cnt    <= '0;
            last_pass_q <= '0;
            last_drop_q <= '0;
        end else if (win_tick) begin
            drop_cnt    <= '0;
            last_pass_q <= pass_nxt;
            last_drop_q <= drop_nxt;
        end else begin
            drop_cnt    <= drop_nxt;
        end
    end

    assign last_pass_cnt = last_pass_q;
    assign last_drop_cnt = last_drop_q;
`else
    assign last_pass_cnt = '0;
    assign last_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_capture_cps_limiter.sv
// tb_capture_cps_limiter: vector table plus randomized traffic against a window-level reference model.
// Latency: n/a.
// Backpressure: out_ready driven always-high, alternating, or random.
module tb_capture_cps_limiter;
    localparam int DATA_W = 64;
    localparam int W      = 100;
    localparam int CNT_W  = 32;
`ifdef CPS_LIM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             user_clk   = 1'b0;
    logic             user_rst_n = 1'b0;
    logic [31:0]      cps_lim;
    logic             win_tick;
    logic             limiting;
    logic [CNT_W-1:0] last_pass_cnt;
    logic [CNT_W-1:0] last_drop_cnt;

    capture_cps_limiter_if #(.DATA_W(DATA_W)) bus ();

    capture_cps_limiter #(
        .DATA_W     (DATA_W),
        .WINDOW_CYC (W),
        .CNT_W      (CNT_W)
    ) dut (
        .user_clk      (user_clk),
        .user_rst_n    (user_rst_n),
        .cps_lim       (cps_lim),
        .bus           (bus.slave),
        .win_tick      (win_tick),
        .limiting      (limiting),
        .last_pass_cnt (last_pass_cnt),
        .last_drop_cnt (last_drop_cnt)
    );

    always #5 user_clk = ~user_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles since reset, per-window tallies, words owed to the output.
    int                cyc;
    longint            lim, wpass, wdrop, lastp, lastd;
    logic [DATA_W-1:0] q[$];

    typedef struct {
        int lim_a;
        int lim_b;
        int chg_at;
        bit alt_ready;
        int n_win;
        int exp_pass;
        int exp_drop;   // -1: not fixed by the vector, model still checks it
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        cyc = 0; lim = 0; wpass = 0; wdrop = 0; lastp = 0; lastd = 0;
        q.delete();
    endtask

    // Compare at the negedge, then advance the model by the coming rising edge.
    task automatic cycle();
        bit rdy;
        bit tick;
        @(negedge user_clk);
        rdy  = (q.size() == 0) || bus.out_ready;
        tick = ((cyc % W) == W - 1);
        chk("evt_ready", bus.evt_ready, rdy);
        chk("out_valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) chk("out_data", bus.out_data, q[0]);
        chk("win_tick", win_tick, tick);
        chk("limiting", limiting, (lim != 0) && (wpass >= lim));
        chk("last_pass_cnt", last_pass_cnt, STATS ? lastp : 0);
        chk("last_drop_cnt", last_drop_cnt, STATS ? lastd : 0);
        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (bus.evt_valid && rdy) begin
            if (lim == 0 || wpass < lim) begin
                q.push_back(bus.evt_data);
                wpass++;
            end else begin
                wdrop++;
            end
        end
        if (tick) begin
            lastp = wpass; lastd = wdrop;
            wpass = 0;     wdrop = 0;
            lim   = cps_lim;
        end
        cyc++;
        @(posedge user_clk);
        #1;
    endtask

    task automatic do_reset();
        user_rst_n    = 1'b0;
        bus.evt_valid = 1'b0;
        bus.evt_data  = '0;
        bus.out_ready = 1'b1;
        cps_lim       = 0;
        repeat (2) @(posedge user_clk);
        #1;
        model_clear();
        user_rst_n = 1'b1;
    endtask

    initial begin
        int seen;
        vecs[0] = '{lim_a:5,  lim_b:5,  chg_at:0,   alt_ready:1'b0, n_win:3, exp_pass:5,   exp_drop:95};
        vecs[1] = '{lim_a:0,  lim_b:0,  chg_at:0,   alt_ready:1'b0, n_win:2, exp_pass:100, exp_drop:0};
        vecs[2] = '{lim_a:5,  lim_b:10, chg_at:150, alt_ready:1'b0, n_win:3, exp_pass:10,  exp_drop:90};
        vecs[3] = '{lim_a:20, lim_b:20, chg_at:0,   alt_ready:1'b1, n_win:2, exp_pass:20,  exp_drop:-1};

        // Reset values while held in reset.
        bus.evt_valid = 1'b0;
        bus.evt_data  = '0;
        bus.out_ready = 1'b1;
        cps_lim       = 0;
        #12;
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_data", bus.out_data, 0);
        chk("rst evt_ready", bus.evt_ready, 1);
        chk("rst win_tick", win_tick, 0);
        chk("rst limiting", limiting, 0);
        chk("rst last_pass_cnt", last_pass_cnt, 0);
        chk("rst last_drop_cnt", last_drop_cnt, 0);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int c = 0; c < vecs[v].n_win * W; c++) begin
                cps_lim       = (c < vecs[v].chg_at) ? vecs[v].lim_a : vecs[v].lim_b;
                bus.evt_valid = 1'b1;
                bus.evt_data  = {$urandom, $urandom};
                bus.out_ready = vecs[v].alt_ready ? c[0] : 1'b1;
                cycle();
            end
            // Cycle after the final tick: snapshot visible, new window back in PASS.
            @(negedge user_clk);
            chk($sformatf("vec%0d last_pass", v), last_pass_cnt, STATS ? vecs[v].exp_pass : 0);
            if (vecs[v].exp_drop >= 0)
                chk($sformatf("vec%0d last_drop", v), last_drop_cnt, STATS ? vecs[v].exp_drop : 0);
            chk($sformatf("vec%0d limiting after tick", v), limiting, 0);
        end

        // Randomized traffic with occasional limit changes.
        do_reset();
        for (int c = 0; c < 6 * W; c++) begin
            if ($urandom_range(0, 49) == 0) cps_lim = $urandom_range(0, 30);
            bus.evt_valid = ($urandom_range(0, 99) < 70);
            bus.evt_data  = {$urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 99) < 60);
            cycle();
        end

        // Reset with a stalled word in the output register.
        do_reset();
        for (int c = 0; c < 37; c++) begin
            bus.evt_valid = 1'b1;
            bus.evt_data  = {$urandom, $urandom};
            bus.out_ready = 1'b0;
            cycle();
        end
        user_rst_n = 1'b0;
        #1;
        chk("mid-reset out_valid", bus.out_valid, 0);
        chk("mid-reset out_data", bus.out_data, 0);
        chk("mid-reset evt_ready", bus.evt_ready, 1);
        bus.evt_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge user_clk);
        #1;
        user_rst_n = 1'b1;
        seen = -1;
        for (int i = 0; i < 150; i++) begin
            @(negedge user_clk);
            if (win_tick) begin
                seen = i;
                break;
            end
        end
        chk("first tick after reset", seen, W - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
